pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with valid/ready handshake,

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_entry.sv | 61 ++++++
 rtl/pipe_stage_buf.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the inter-stage pipeline registers.
//                Holds the occupancy encoding (also used as the skid-buffer
//                state encoding) and the default payload widths used by all
//                stage instances.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Default payload widths shared by ID/EX, EX/MEM and MEM/WB instances.
    localparam int unsigned DEFAULT_DATA_W = 134;
    localparam int unsigned DEFAULT_CTRL_W = 16;

    // Occupancy encoding; doubles as the state encoding of the skid FSM.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry
//  Description : One pipeline-register entry: a valid bit plus a payload
//                register. Clear beats load; reset beats both. Clear leaves
//                the payload untouched (only the valid bit is dropped).
//  Ports       : Clk_i     stage clock (state updates on falling edge)
//                Resetn_i  synchronous reset, active low
//                clr_i     drop the valid bit
//                ld_i      capture d_i and set valid
//                d_i       payload to capture
//                valid_o   entry holds a beat
//                q_o       held payload
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned W = DEFAULT_DATA_W + DEFAULT_CTRL_W
) (
    input  logic         Clk_i,
    input  logic         Resetn_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (ld_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    // Pipeline registers of this core all update on the falling edge.
    always_ff @(negedge Clk_i) begin
        if (!Resetn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Inter-stage pipeline register with valid/ready handshake,
//                optional 2-entry skid buffer, synchronous flush and
//                bubble-gated control output. Contains only handshake and
//                state logic; storage lives in pipe_entry instances.
//  Ports       : Clk_i        stage clock (state updates on falling edge)
//                Resetn_i     synchronous reset, active low
//                flush_i      discard held and incoming beats this edge
//                in_valid_i   upstream beat valid
//                in_ready_o   stage can accept a beat
//                in_data_i    upstream datapath payload
//                in_ctrl_i    upstream control payload
//                out_valid_o  downstream beat valid
//                out_ready_i  downstream accepts (0 = stall)
//                out_data_o   head datapath payload
//                out_ctrl_o   head control payload, zero on bubbles
//                occupancy_o  entries held (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              Clk_i,
    input  logic              Resetn_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o
);

    localparam int unsigned PW = DATA_W + CTRL_W;

    // Head entry controls; driven by whichever handshake variant is built.
    logic          w_h_valid;
    logic [PW-1:0] w_h_payload;
    logic          w_h_ld;
    logic          w_h_clr;
    logic [PW-1:0] w_h_din;

    pipe_entry #(.W(PW)) u_head (
        .Clk_i    (Clk_i),
        .Resetn_i (Resetn_i),
        .clr_i    (w_h_clr),
        .ld_i     (w_h_ld),
        .d_i      (w_h_din),
        .valid_o  (w_h_valid),
        .q_o      (w_h_payload)
    );

    generate
        if (SKID) begin : g_skid
            logic          w_s_valid;
            logic [PW-1:0] w_s_payload;
            logic          w_s_ld;
            logic          w_s_clr;
            logic          w_in_fire;
            logic          w_out_fire;
            logic [1:0]    occ_q;
            logic [1:0]    occ_d;

            pipe_entry #(.W(PW)) u_skid (
                .Clk_i    (Clk_i),
                .Resetn_i (Resetn_i),
                .clr_i    (w_s_clr),
                .ld_i     (w_s_ld),
                .d_i      ({in_data_i, in_ctrl_i}),
                .valid_o  (w_s_valid),
                .q_o      (w_s_payload)
            );

            // Ready comes straight from a flop: no path from out_ready_i.
            assign in_ready_o = ~w_s_valid;
            assign w_in_fire  = in_valid_i & ~w_s_valid;
            assign w_out_fire = w_h_valid & out_ready_i;

            always_comb begin
                w_h_ld  = 1'b0;
                w_h_clr = 1'b0;
                w_h_din = {in_data_i, in_ctrl_i};
                w_s_ld  = 1'b0;
                w_s_clr = 1'b0;
                occ_d   = occ_q;
                if (flush_i) begin
                    // Incoming beat is dropped; a beat leaving this edge is
                    // still considered delivered downstream.
                    w_h_clr = 1'b1;
                    w_s_clr = 1'b1;
                    occ_d   = OCC_EMPTY;
                end else begin
                    case (occ_q)
                        OCC_EMPTY: begin
                            if (w_in_fire) begin
                                w_h_ld = 1'b1;
                                occ_d  = OCC_ONE;
                            end
                        end
                        OCC_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                w_h_ld = 1'b1;
                            end else if (w_in_fire) begin
                                w_s_ld = 1'b1;
                                occ_d  = OCC_TWO;
                            end else if (w_out_fire) begin
                                w_h_clr = 1'b1;
                                occ_d   = OCC_EMPTY;
                            end
                        end
                        OCC_TWO: begin
                            // Skid entry is older than anything upstream, so
                            // it refills the head before new input is taken.
                            if (w_out_fire) begin
                                w_h_ld  = 1'b1;
                                w_h_din = w_s_payload;
                                w_s_clr = 1'b1;
                                occ_d   = OCC_ONE;
                            end
                        end
                        default: begin
                            w_h_clr = 1'b1;
                            w_s_clr = 1'b1;
                            occ_d   = OCC_EMPTY;
                        end
                    endcase
                end
            end

            always_ff @(negedge Clk_i) begin
                if (!Resetn_i) begin
                    occ_q <= OCC_EMPTY;
                end else begin
                    occ_q <= occ_d;
                end
            end

            assign occupancy_o = occ_q;
        end else begin : g_noskid
            logic w_in_fire;
            logic w_out_fire;

            // Single entry: the slot frees up in the same cycle it drains.
            assign in_ready_o  = out_ready_i | ~w_h_valid;
            assign w_in_fire   = in_valid_i & in_ready_o;
            assign w_out_fire  = w_h_valid & out_ready_i;
            assign w_h_ld      = w_in_fire;
            assign w_h_clr     = flush_i | (w_out_fire & ~w_in_fire);
            assign w_h_din     = {in_data_i, in_ctrl_i};
            assign occupancy_o = {1'b0, w_h_valid};
        end
    endgenerate

    assign out_valid_o = w_h_valid;
    assign out_data_o  = w_h_payload[PW-1:CTRL_W];
    // Bubbles must never present write enables to the next stage.
    assign out_ctrl_o  = w_h_payload[CTRL_W-1:0] & {CTRL_W{w_h_valid}};

endmodule : pipe_stage_buf
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Bench for pipe_stage_buf. Drives one SKID=1 and one SKID=0
//                instance from shared stimulus; a vector table checks
//                occupancy/ready/head state per edge, a scoreboard per
//                instance checks FIFO order of every delivered beat, and
//                short hand-written sequences cover the corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int unsigned DW = DEFAULT_DATA_W;
    localparam int unsigned CW = DEFAULT_CTRL_W;
    localparam int          NV = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          flush;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] idata;
    logic [CW-1:0] ictrl;

    logic          a_ir, a_ov, b_ir, b_ov;
    logic [DW-1:0] a_odata, b_odata;
    logic [CW-1:0] a_octrl, b_octrl;
    logic [1:0]    a_occ, b_occ;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut_a (
        .Clk_i(clk), .Resetn_i(rstn), .flush_i(flush),
        .in_valid_i(iv), .in_ready_o(a_ir), .in_data_i(idata), .in_ctrl_i(ictrl),
        .out_valid_o(a_ov), .out_ready_i(ordy), .out_data_o(a_odata),
        .out_ctrl_o(a_octrl), .occupancy_o(a_occ)
    );

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut_b (
        .Clk_i(clk), .Resetn_i(rstn), .flush_i(flush),
        .in_valid_i(iv), .in_ready_o(b_ir), .in_data_i(idata), .in_ctrl_i(ictrl),
        .out_valid_o(b_ov), .out_ready_i(ordy), .out_data_o(b_odata),
        .out_ctrl_o(b_octrl), .occupancy_o(b_occ)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic [15:0] c;
        logic        ordy;
        logic        fl;
        logic [1:0]  occ_a;
        logic        ir_a;
        logic        ov_a;
        logic [7:0]  dat_a;
        logic [15:0] ctl_a;
        logic [1:0]  occ_b;
    } vec_t;

    vec_t  vt [NV];
    beat_t qa [$];
    beat_t qb [$];
    beat_t ea;
    beat_t eb;
    int    n_checks = 0;
    int    n_err    = 0;
    int    pops_a   = 0;
    int    pops_b   = 0;
    bit    mon_en   = 1'b0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: decisions taken at the rising edge, half a cycle away from
    // the falling edge where the DUTs update.
    always @(posedge clk) begin
        if (mon_en) begin
            if (!rstn) begin
                qa.delete();
                qb.delete();
            end else begin
                if (a_ov && ordy) begin
                    if (qa.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL a_unexpected_beat: got %0h expected none", a_odata);
                    end else begin
                        ea = qa.pop_front();
                        pops_a++;
                        chk("a_sb_data", 160'(a_odata), 160'(ea.d));
                        chk("a_sb_ctrl", 160'(a_octrl), 160'(ea.c));
                    end
                end
                if (!a_ov) chk("a_bubble_ctrl", 160'(a_octrl), 160'(0));
                if (flush) qa.delete();
                else if (iv && a_ir) qa.push_back({idata, ictrl});

                if (b_ov && ordy) begin
                    if (qb.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL b_unexpected_beat: got %0h expected none", b_odata);
                    end else begin
                        eb = qb.pop_front();
                        pops_b++;
                        chk("b_sb_data", 160'(b_odata), 160'(eb.d));
                        chk("b_sb_ctrl", 160'(b_octrl), 160'(eb.c));
                    end
                end
                if (!b_ov) chk("b_bubble_ctrl", 160'(b_octrl), 160'(0));
                if (flush) qb.delete();
                else if (iv && b_ir) qb.push_back({idata, ictrl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          iv    d      c        ordy  fl    occA  irA   ovA   datA   ctlA      occB
        vt[0]  = '{1'b1, 8'h11, 16'h5A11, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h11, 16'h5A11, 2'd1};
        vt[1]  = '{1'b1, 8'h22, 16'h5A22, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h22, 16'h5A22, 2'd1};
        vt[2]  = '{1'b1, 8'h33, 16'h5A33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'h33, 16'h5A33, 2'd1};
        vt[3]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};
        vt[4]  = '{1'b1, 8'hA1, 16'h5AA1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA1, 16'h5AA1, 2'd1};
        vt[5]  = '{1'b1, 8'hA2, 16'h5AA2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hA1, 16'h5AA1, 2'd1};
        vt[6]  = '{1'b1, 8'hA3, 16'h5AA3, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hA1, 16'h5AA1, 2'd1};
        vt[7]  = '{1'b1, 8'hA3, 16'h5AA3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA2, 16'h5AA2, 2'd1};
        vt[8]  = '{1'b1, 8'hA3, 16'h5AA3, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA3, 16'h5AA3, 2'd1};
        vt[9]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};
        vt[10] = '{1'b1, 8'hB1, 16'h5AB1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'hB1, 16'h5AB1, 2'd1};
        vt[11] = '{1'b1, 8'hB2, 16'h5AB2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 8'hB1, 16'h5AB1, 2'd1};
        vt[12] = '{1'b1, 8'hB3, 16'h5AB3, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};
        vt[13] = '{1'b1, 8'hC1, 16'h5AC1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'hC1, 16'h5AC1, 2'd1};
        vt[14] = '{1'b1, 8'hC2, 16'h5AC2, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};
        vt[15] = '{1'b1, 8'hD1, 16'h5AD1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 8'hD1, 16'h5AD1, 2'd1};
        vt[16] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};
        vt[17] = '{1'b1, 8'hE1, 16'hFFFF, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 8'hE1, 16'hFFFF, 2'd1};
        vt[18] = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0};

        // Reset held two edges with a valid beat presented upstream.
        rstn  = 1'b0;
        flush = 1'b0;
        iv    = 1'b1;
        idata = DW'(8'h5C);
        ictrl = '1;
        ordy  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_a_ov",    160'(a_ov),    160'(0));
            chk("rst_a_ctrl",  160'(a_octrl), 160'(0));
            chk("rst_a_occ",   160'(a_occ),   160'(0));
            chk("rst_a_ready", 160'(a_ir),    160'(1));
            chk("rst_b_ov",    160'(b_ov),    160'(0));
            chk("rst_b_ctrl",  160'(b_octrl), 160'(0));
            chk("rst_b_occ",   160'(b_occ),   160'(0));
        end
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Stream, stall, flush and bubble-gating vectors.
        for (int i = 0; i < NV; i++) begin
            iv    = vt[i].iv;
            idata = DW'(vt[i].d);
            ictrl = vt[i].c;
            ordy  = vt[i].ordy;
            flush = vt[i].fl;
            tick();
            chk($sformatf("v%0d_a_occ", i),   160'(a_occ),   160'(vt[i].occ_a));
            chk($sformatf("v%0d_a_ready", i), 160'(a_ir),    160'(vt[i].ir_a));
            chk($sformatf("v%0d_a_ov", i),    160'(a_ov),    160'(vt[i].ov_a));
            chk($sformatf("v%0d_a_ctrl", i),  160'(a_octrl), 160'(vt[i].ctl_a));
            if (vt[i].ov_a)
                chk($sformatf("v%0d_a_data", i), 160'(a_odata), 160'(vt[i].dat_a));
            chk($sformatf("v%0d_b_occ", i),   160'(b_occ),   160'(vt[i].occ_b));
        end
        flush = 1'b0;

        // Single-entry variant: combinational ready and same-edge replace.
        iv    = 1'b1;
        idata = DW'(8'hF1);
        ictrl = 16'h5AF1;
        ordy  = 1'b0;
        tick();
        chk("t6_a_occ_load", 160'(a_occ), 160'(1));
        chk("t6_b_occ_load", 160'(b_occ), 160'(1));
        idata = DW'(8'hF2);
        ictrl = 16'h5AF2;
        #1;
        chk("t6_b_ready_stall", 160'(b_ir), 160'(0));
        chk("t6_a_ready_one",   160'(a_ir), 160'(1));
        ordy = 1'b1;
        #1;
        chk("t6_b_ready_comb",  160'(b_ir), 160'(1));
        tick();
        chk("t6_b_occ_replace",  160'(b_occ),   160'(1));
        chk("t6_b_data_replace", 160'(b_odata), 160'(8'hF2));
        chk("t6_a_occ_replace",  160'(a_occ),   160'(1));
        chk("t6_a_data_replace", 160'(a_odata), 160'(8'hF2));
        iv = 1'b0;
        tick();
        chk("t6_a_occ_drain", 160'(a_occ), 160'(0));
        chk("t6_b_occ_drain", 160'(b_occ), 160'(0));

        // Reset while stalled with both skid entries full.
        iv    = 1'b1;
        idata = DW'(8'h77);
        ictrl = 16'h5A77;
        ordy  = 1'b0;
        tick();
        idata = DW'(8'h78);
        ictrl = 16'h5A78;
        tick();
        chk("rs_a_occ_full",  160'(a_occ), 160'(2));
        chk("rs_a_ready_low", 160'(a_ir),  160'(0));
        rstn = 1'b0;
        tick();
        chk("rs_a_occ",  160'(a_occ),   160'(0));
        chk("rs_a_ov",   160'(a_ov),    160'(0));
        chk("rs_a_ctrl", 160'(a_octrl), 160'(0));
        chk("rs_a_data", 160'(a_odata), 160'(0));
        chk("rs_b_occ",  160'(b_occ),   160'(0));
        rstn = 1'b1;
        iv   = 1'b0;
        #1;
        chk("rs_a_ready_after", 160'(a_ir), 160'(1));
        chk("rs_b_ready_after", 160'(b_ir), 160'(1));
        tick();
        tick();

        // Every surviving beat delivered exactly once, nothing left over.
        chk("a_beats_delivered", 160'(pops_a),    160'(10));
        chk("b_beats_delivered", 160'(pops_b),    160'(10));
        chk("a_sb_leftover",     160'(qa.size()), 160'(0));
        chk("b_sb_leftover",     160'(qb.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_buf
`default_nettype wire
